// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port synchronous-read memory between the
//            instruction-fetch stage and the MEM-stage load/store port.
//            Data accesses win contested cycles unless fetch has been denied
//            STARVE_MAX cycles in a row. Read data is routed back to whichever
//            requester was granted on the previous cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  // instruction fetch port
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_valid,
  output logic [DW-1:0] o_if_rdata,
  // data (load/store) port
  input  logic          i_mem_rd,
  input  logic          i_mem_wr,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_mem_wdata,
  output logic          o_mem_gnt,
  output logic          o_mem_valid,
  output logic [DW-1:0] o_mem_rdata,
  // pipeline freeze requests
  output logic          o_stall_if,
  output logic          o_stall_mem,
  // memory side
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata,
  // sticky protocol error
  output logic          o_err
);

  // Response owner encoding: who receives ram_rdata on the current cycle.
  localparam logic [1:0] c_OWN_NONE = 2'd0;
  localparam logic [1:0] c_OWN_IF   = 2'd1;
  localparam logic [1:0] c_OWN_MEM  = 2'd2;

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
  localparam logic [3:0] c_CNT_SAT    = 4'hF;

  logic [3:0] r_starve_cnt;
  logic [1:0] r_owner;
  logic [1:0] w_owner_nxt;
  logic       r_err;

  logic       w_mem_req;
  logic       w_fetch_wins;
  logic       w_if_gnt;
  logic       w_mem_gnt;

  assign w_mem_req    = i_mem_rd | i_mem_wr;
  assign w_fetch_wins = (r_starve_cnt >= c_STARVE_MAX);

  // Grant decision: data has priority unless fetch has starved long enough.
  always_comb begin
    w_if_gnt  = 1'b0;
    w_mem_gnt = 1'b0;
    if (!rst) begin
      if (i_if_req && !w_mem_req) begin
        w_if_gnt = 1'b1;
      end else if (w_mem_req && !i_if_req) begin
        w_mem_gnt = 1'b1;
      end else if (w_mem_req && i_if_req) begin
        if (w_fetch_wins) begin
          w_if_gnt = 1'b1;
        end else begin
          w_mem_gnt = 1'b1;
        end
      end
    end
  end

  assign o_if_gnt    = w_if_gnt;
  assign o_mem_gnt   = w_mem_gnt;
  assign o_stall_if  = i_if_req  & ~w_if_gnt;
  assign o_stall_mem = w_mem_req & ~w_mem_gnt;

  // Memory drive: a simultaneous rd+wr is executed as a store.
  always_comb begin
    o_ram_en    = w_if_gnt | w_mem_gnt;
    o_ram_we    = w_mem_gnt & i_mem_wr;
    o_ram_addr  = w_if_gnt ? i_if_addr : i_mem_addr;
    o_ram_wdata = i_mem_wdata;
  end

  // Count consecutive denied fetch cycles, saturating; any grant or idle
  // cycle on the fetch side restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (i_if_req && !w_if_gnt) begin
      if (r_starve_cnt != c_CNT_SAT) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

  // Response owner register; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= c_OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Next owner: reads produce a response next cycle, stores do not.
  always_comb begin
    w_owner_nxt = c_OWN_NONE;
    if (w_if_gnt) begin
      w_owner_nxt = c_OWN_IF;
    end else if (w_mem_gnt && !i_mem_wr) begin
      w_owner_nxt = c_OWN_MEM;
    end
  end

  // Route synchronous read data to its owner; the other port sees zero.
  always_comb begin
    o_if_valid  = 1'b0;
    o_mem_valid = 1'b0;
    o_if_rdata  = '0;
    o_mem_rdata = '0;
    case (r_owner)
      c_OWN_IF: begin
        o_if_valid = 1'b1;
        o_if_rdata = i_ram_rdata;
      end
      c_OWN_MEM: begin
        o_mem_valid = 1'b1;
        o_mem_rdata = i_ram_rdata;
      end
      default: begin
        o_if_valid  = 1'b0;
        o_mem_valid = 1'b0;
      end
    endcase
  end

  // Sticky error flag for an illegal simultaneous load+store request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (i_mem_rd && i_mem_wr) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule

`default_nettype wire
